// File: rtl/reg_bank_ctr_if.sv
// -----------------------------------------------------------------------------
// reg_bank_ctr_if
// Bundles the operation/bus signals between the datapath controller and the
// register bank so both sides see one named connection.
//
// Signals:
//   op      operation code for register `sel`
//   sel     destination register index
//   rd_sel  read index for out/zero, also COPY source
//   bus1    accumulator/ALU result bus
//   bus2    data/memory bus
//   limit   wrap limit used by INC/DEC
//   out     R[rd_sel] (combinational)
//   zero    high when out == 0 (combinational)
//   wrap    registered one-cycle pulse after an INC/DEC wrap
//
// Modports:
//   master  controller side, drives the op/bus signals and reads results
//   slave   register bank side
// -----------------------------------------------------------------------------
interface reg_bank_ctr_if #(
    parameter int WIDTH = 8,
    parameter int SELW  = 2
);

    logic [2:0]       op;
    logic [SELW-1:0]  sel;
    logic [SELW-1:0]  rd_sel;
    logic [WIDTH-1:0] bus1;
    logic [WIDTH-1:0] bus2;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] out;
    logic             zero;
    logic             wrap;

    modport master (
        output op,
        output sel,
        output rd_sel,
        output bus1,
        output bus2,
        output limit,
        input  out,
        input  zero,
        input  wrap
    );

    modport slave (
        input  op,
        input  sel,
        input  rd_sel,
        input  bus1,
        input  bus2,
        input  limit,
        output out,
        output zero,
        output wrap
    );

endinterface

// File: rtl/reg_bank_ctr.sv
// -----------------------------------------------------------------------------
// reg_bank_ctr
// Bank of NREGS general-purpose registers for the down-sampling datapath.
// Each register can load from bus1 or bus2, clear, copy from another
// register, or count up/down with a programmable wrap limit. One register is
// read combinationally onto `out` together with a zero flag. All state
// updates happen on the falling edge of clk; the controller drives the inputs
// on the rising edge so they are stable at the update edge.
//
// Parameters:
//   WIDTH  register and bus width in bits
//   NREGS  number of registers, 2..2**SELW
//   SELW   width of the register select fields
//
// Ports:
//   clk    clock, state updates on the falling edge
//   rst    synchronous active-high reset, sampled on the falling edge
//   bus    reg_bank_ctr_if slave modport (op, sel, rd_sel, bus1, bus2,
//          limit in; out, zero, wrap out)
// -----------------------------------------------------------------------------
module reg_bank_ctr #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4,
    parameter int SELW  = 2
) (
    input  logic           clk,
    input  logic           rst,
    reg_bank_ctr_if.slave  bus
);

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LD1  = 3'b001,
        OP_LD2  = 3'b010,
        OP_CLR  = 3'b011,
        OP_INC  = 3'b100,
        OP_DEC  = 3'b101,
        OP_COPY = 3'b110,
        OP_RSVD = 3'b111
    } opcode_t;

    // Register count expressed one bit wider than the select fields so that
    // NREGS == 2**SELW still fits and index checks stay width-matched.
    localparam logic [SELW:0]    NREGS_W = (SELW+1)'(NREGS);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] ALL1    = '1;

    logic [WIDTH-1:0] r_regs [NREGS];
    logic             r_wrap;

    logic             w_selValid;
    logic             w_rdValid;
    logic [WIDTH-1:0] w_rdData;
    logic [WIDTH-1:0] w_curVal;
    logic [WIDTH-1:0] w_nextVal;
    logic             w_wrEn;
    logic             w_wrapNext;
    opcode_t          w_op;

    assign w_selValid = ({1'b0, bus.sel}    < NREGS_W);
    assign w_rdValid  = ({1'b0, bus.rd_sel} < NREGS_W);
    assign w_op       = opcode_t'(bus.op);

    // Read port: an out-of-range read index returns zero, which also makes a
    // COPY from a non-existent register write zero.
    always_comb begin
        w_rdData = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (w_rdValid && ({1'b0, bus.rd_sel} == (SELW+1)'(i))) begin
                w_rdData = r_regs[i];
            end
        end
    end

    // Current value of the destination register, used by INC/DEC to decide
    // whether this edge wraps.
    always_comb begin
        w_curVal = '0;
        for (int i = 0; i < NREGS; i++) begin
            if ({1'b0, bus.sel} == (SELW+1)'(i)) begin
                w_curVal = r_regs[i];
            end
        end
    end

    // Operation decode. Writes to an out-of-range destination are dropped and
    // never raise wrap. INC treats all-ones as a second wrap point so a
    // register loaded above the limit still counts up and wraps to zero.
    always_comb begin
        w_wrEn     = 1'b0;
        w_nextVal  = w_curVal;
        w_wrapNext = 1'b0;
        unique case (w_op)
            OP_LD1: begin
                w_wrEn    = 1'b1;
                w_nextVal = bus.bus1;
            end
            OP_LD2: begin
                w_wrEn    = 1'b1;
                w_nextVal = bus.bus2;
            end
            OP_CLR: begin
                w_wrEn    = 1'b1;
                w_nextVal = '0;
            end
            OP_INC: begin
                w_wrEn = 1'b1;
                if ((w_curVal == bus.limit) || (w_curVal == ALL1)) begin
                    w_nextVal  = '0;
                    w_wrapNext = 1'b1;
                end else begin
                    w_nextVal = w_curVal + ONE;
                end
            end
            OP_DEC: begin
                w_wrEn = 1'b1;
                if (w_curVal == '0) begin
                    w_nextVal  = bus.limit;
                    w_wrapNext = 1'b1;
                end else begin
                    w_nextVal = w_curVal - ONE;
                end
            end
            OP_COPY: begin
                w_wrEn    = (bus.sel != bus.rd_sel);
                w_nextVal = w_rdData;
            end
            OP_NOP, OP_RSVD: begin
                w_wrEn = 1'b0;
            end
            default: begin
                w_wrEn = 1'b0;
            end
        endcase
        if (!w_selValid) begin
            w_wrEn     = 1'b0;
            w_wrapNext = 1'b0;
        end
    end

    // Register bank and wrap pulse, updated on the falling edge. Reset wins
    // over any operation presented in the same cycle and that operation is
    // simply lost. wrap is rewritten every edge so it lasts exactly one cycle
    // unless the next op wraps again.
    always_ff @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_wrap <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (w_wrEn && ({1'b0, bus.sel} == (SELW+1)'(i))) begin
                    r_regs[i] <= w_nextVal;
                end
            end
            r_wrap <= w_wrapNext;
        end
    end

    assign bus.out  = w_rdData;
    assign bus.zero = (w_rdData == '0);
    assign bus.wrap = r_wrap;

endmodule

// File: doc/reg_bank_ctr.md
# reg_bank_ctr

Parametrised bank of NREGS general-purpose registers for the down-sampling processor datapath, the generalised successor to the single operand register. Each register loads from the accumulator/ALU bus (bus1) or the data/memory bus (bus2), clears, copies from another register, and counts up or down with a programmable wrap limit. The counting mode supports pixel row/column indexing without ALU cycles. One register is read combinationally per cycle onto `out`, with a zero flag.

## Interface
- WIDTH, 8, register and bus width in bits
- NREGS, 4, number of registers, 2..2**SELW
- SELW, 2, width of register select fields
- clk  in  1  clock; all state updates on the falling edge
- rst  in  1  synchronous, active-high reset; sampled on the falling edge of clk
- op  in  3  operation code, applied to register `sel`
- sel  in  SELW  destination register index
- rd_sel  in  SELW  read index for `out`/`zero`; also source for COPY
- bus1  in  WIDTH  accumulator/ALU result bus
- bus2  in  WIDTH  data/memory bus
- limit  in  WIDTH  wrap limit for INC/DEC
- out  out  WIDTH  R[rd_sel], combinational
- zero  out  1  high when out == 0, combinational
- wrap  out  1  registered one-cycle pulse; high for the cycle after an INC/DEC wraps

## Operation
- Opcodes, applied to R[sel] at the falling edge:
  - 000 NOP: no change
  - 001 LD1: R[sel] <= bus1
  - 010 LD2: R[sel] <= bus2
  - 011 CLR: R[sel] <= 0
  - 100 INC: if R[sel] == limit or R[sel] == all-ones, R[sel] <= 0 and wrap <= 1; else R[sel] <= R[sel]+1
  - 101 DEC: if R[sel] == 0, R[sel] <= limit and wrap <= 1; else R[sel] <= R[sel]-1
  - 110 COPY: R[sel] <= R[rd_sel], using the pre-edge value; sel == rd_sel is a no-op
  - 111: reserved, treated as NOP
- Arithmetic is unsigned modulo 2**WIDTH. No carry or overflow output other than `wrap`.
- If R[sel] > limit, INC counts up to all-ones and then wraps to 0 with wrap = 1.
- `wrap` is cleared on every edge where no wrap occurs, including on NOP.
- sel >= NREGS: the write is ignored and wrap = 0.
- rd_sel >= NREGS: out = 0 and zero = 1. A COPY from that index writes 0.
- Only one register changes per cycle. All other registers hold.

## Timing
- Reset: on a falling edge with rst = 1, all R[i] = 0 and wrap = 0. rst overrides any op in the same cycle. The op is discarded, not deferred.
- After reset release: out = 0 and zero = 1 until the first write.
- Write latency: 1 clk edge. The new value is visible on `out` immediately after the falling edge when rd_sel == sel.
- Read-during-write to the same register returns the old value before the edge and the new value after it. There is no bypass.
- `wrap` is valid for exactly one cycle, from the falling edge that performs the wrap to the next falling edge. Back-to-back wrapping ops keep it high continuously.
- The inputs op, sel, rd_sel, bus1, bus2 and limit must be stable around the falling edge. They are driven by the controller on the rising edge.

## Test plan
- Reset: load R0..R3 = 8'h11, 22, 33, 44. Assert rst with op = LD1 in the same cycle -> all registers read 0 and wrap = 0; the LD1 has no effect.
- Loads and copy: LD1 R1 with bus1 = 8'hA5, then LD2 R2 with bus2 = 8'h3C, then COPY R3 <= R1 (rd_sel = 1) -> reading 1/2/3 gives A5/3C/A5; R0 = 0 and zero = 1 when reading R0.
- INC wrap: limit = 8'd3, CLR R0, then INC ×4 -> R0 goes 1, 2, 3, 0; wrap pulses high only after the 4th edge, and zero = 1 at that point.
- DEC wrap: limit = 8'd5, R2 = 1, DEC ×3 -> R2 goes 0, 5, 4; wrap is high only for the cycle after the 5 is written.
- Above-limit and boundaries: limit = 8'd10 and R1 = 8'hFE, INC ×2 -> R1 = FF, then 00 with wrap = 1. Next, NREGS = 3 (SELW = 2) with sel = 3 and LD1 -> no register changes. Finally, rd_sel = 3 -> out = 0 and zero = 1.
